// File: rtl/triangle_feeder.sv
// ---------------------------------------------------------------------------
// triangle_feeder
//
// Walks a triangle list held in block RAM and hands triangles to the
// rasterizer one at a time over a valid/ready handshake. A new_frame pulse
// starts a walk at address 0. Each record is fetched, waited on for the RAM
// latency, captured into the vertex registers, optionally checked for zero
// signed area, and then presented until accepted. When the list is exhausted
// obj_done pulses for one cycle.
//
// Ports
//   clk_in     system clock
//   rst_in     synchronous active-high reset (priority over new_frame)
//   new_frame  1-cycle start pulse; also aborts and restarts a running walk
//   num_tri    triangles in the object, sampled on new_frame (clamped to MAX_TRI)
//   tri_addr   RAM read address
//   tri_data   RAM record {v1,v2,v3}, each vertex {x,y,z}, v1.x in the MSBs
//   vert1..3   captured vertices, [2]=x [1]=y [0]=z
//   valid_tri  vert1..3 hold a triangle awaiting acceptance
//   ready_in   rasterizer ready; transfer when valid_tri & ready_in
//   obj_done   1-cycle pulse after the last transfer (or last skip)
//   busy       high from new_frame through the obj_done cycle
//   sent_cnt   triangles transferred in this frame (skipped ones excluded)
// ---------------------------------------------------------------------------
module triangle_feeder #(
  parameter int COORD_W    = 9,
  parameter int MAX_TRI    = 256,
  parameter int BRAM_LAT   = 2,
  parameter int SKIP_DEGEN = 1,
  localparam int ADDR_W    = $clog2(MAX_TRI)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         new_frame,
  input  logic [ADDR_W:0]              num_tri,
  output logic [ADDR_W-1:0]            tri_addr,
  input  logic [9*COORD_W-1:0]         tri_data,
  output logic [2:0][COORD_W-1:0]      vert1,
  output logic [2:0][COORD_W-1:0]      vert2,
  output logic [2:0][COORD_W-1:0]      vert3,
  output logic                         valid_tri,
  input  logic                         ready_in,
  output logic                         obj_done,
  output logic                         busy,
  output logic [ADDR_W:0]              sent_cnt
);

  localparam int WAIT_W = (BRAM_LAT > 1) ? $clog2(BRAM_LAT) : 1;
  localparam int DIFF_W = COORD_W + 1;
  localparam int AREA_W = 2 * COORD_W + 2;
  localparam logic [ADDR_W:0]   MAX_CNT   = (ADDR_W + 1)'(MAX_TRI);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(BRAM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_CHECK,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t                    state_reg, state_next;
  logic [ADDR_W:0]           idx_reg, idx_next;
  logic [ADDR_W:0]           num_reg, num_next;
  logic [ADDR_W:0]           sent_reg, sent_next;
  logic [ADDR_W-1:0]         addr_reg, addr_next;
  logic [WAIT_W-1:0]         wait_reg, wait_next;
  logic [2:0][COORD_W-1:0]   v1_reg, v1_next;
  logic [2:0][COORD_W-1:0]   v2_reg, v2_next;
  logic [2:0][COORD_W-1:0]   v3_reg, v3_next;

  // Split the RAM record into its three vertices (v1 occupies the top slice).
  logic [2:0][COORD_W-1:0]   rec_vert [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_unpack
      assign rec_vert[gi] = tri_data[(9 - 3*gi)*COORD_W-1 -: 3*COORD_W];
    end
  endgenerate

  // Twice the signed area from the captured vertices. Coordinate differences
  // need one extra bit for the sign; the products and their difference fit
  // exactly in 2*COORD_W+2 signed bits, so no overflow is possible.
  logic signed [DIFF_W-1:0]  dx2, dy2, dx3, dy3;
  logic signed [AREA_W-1:0]  prod_a, prod_b, area2;
  logic                      degen;

  always_comb begin
    dx2    = $signed({1'b0, v2_reg[2]}) - $signed({1'b0, v1_reg[2]});
    dy2    = $signed({1'b0, v2_reg[1]}) - $signed({1'b0, v1_reg[1]});
    dx3    = $signed({1'b0, v3_reg[2]}) - $signed({1'b0, v1_reg[2]});
    dy3    = $signed({1'b0, v3_reg[1]}) - $signed({1'b0, v1_reg[1]});
    prod_a = AREA_W'(dx2) * AREA_W'(dy3);
    prod_b = AREA_W'(dx3) * AREA_W'(dy2);
    area2  = prod_a - prod_b;
    degen  = (area2 == '0);
  end

  // Requested count clamped to the RAM depth.
  logic [ADDR_W:0] num_clamped;
  assign num_clamped = (num_tri > MAX_CNT) ? MAX_CNT : num_tri;

  // Next-state and datapath updates.
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    num_next   = num_reg;
    sent_next  = sent_reg;
    addr_next  = addr_reg;
    wait_next  = wait_reg;
    v1_next    = v1_reg;
    v2_next    = v2_reg;
    v3_next    = v3_reg;

    case (state_reg)
      S_IDLE: ;

      S_FETCH: begin
        state_next = S_WAIT;
        wait_next  = WAIT_INIT;
      end

      S_WAIT: begin
        if (wait_reg == '0) begin
          v1_next    = rec_vert[0];
          v2_next    = rec_vert[1];
          v3_next    = rec_vert[2];
          state_next = S_CHECK;
        end else begin
          wait_next = wait_reg - 1'b1;
        end
      end

      S_CHECK: begin
        if ((SKIP_DEGEN != 0) && degen) begin
          idx_next   = idx_reg + 1'b1;
          state_next = (idx_next == num_reg) ? S_DONE : S_FETCH;
        end else begin
          state_next = S_PRESENT;
        end
      end

      S_PRESENT: begin
        if (ready_in) begin
          sent_next  = sent_reg + 1'b1;
          idx_next   = idx_reg + 1'b1;
          state_next = (idx_next == num_reg) ? S_DONE : S_FETCH;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    // A start pulse wins in every state: an idle FSM starts, a running walk
    // is abandoned (in-flight triangle dropped, no obj_done), and a DONE
    // cycle still shows its obj_done before the restart takes effect.
    if (new_frame) begin
      num_next   = num_clamped;
      idx_next   = '0;
      sent_next  = '0;
      state_next = (num_clamped == '0) ? S_DONE : S_FETCH;
    end

    // The address register only moves when a fetch is about to happen, so
    // it never points past num_tri-1.
    if (state_next == S_FETCH) begin
      addr_next = idx_next[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg <= S_IDLE;
      idx_reg   <= '0;
      num_reg   <= '0;
      sent_reg  <= '0;
      addr_reg  <= '0;
      wait_reg  <= '0;
      v1_reg    <= '0;
      v2_reg    <= '0;
      v3_reg    <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      num_reg   <= num_next;
      sent_reg  <= sent_next;
      addr_reg  <= addr_next;
      wait_reg  <= wait_next;
      v1_reg    <= v1_next;
      v2_reg    <= v2_next;
      v3_reg    <= v3_next;
    end
  end

  // Handshake and status outputs decode the registered state.
  always_comb begin
    valid_tri = 1'b0;
    obj_done  = 1'b0;
    busy      = 1'b0;
    case (state_reg)
      S_IDLE:    busy = 1'b0;
      S_PRESENT: begin
        valid_tri = 1'b1;
        busy      = 1'b1;
      end
      S_DONE: begin
        obj_done = 1'b1;
        busy     = 1'b1;
      end
      default:   busy = 1'b1;
    endcase
  end

  assign tri_addr = addr_reg;
  assign vert1    = v1_reg;
  assign vert2    = v2_reg;
  assign vert3    = v3_reg;
  assign sent_cnt = sent_reg;

endmodule
